// File: rtl/reg_writeback_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback wins, and MDU results
// drain from a small FIFO. A busy scoreboard, a WAW flag and a starvation stall are kept alongside.
module reg_writeback_arbiter #(
  parameter int MDU_DEPTH  = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_wren,
  input  logic [4:0]  pipe_waddr,
  input  logic [31:0] pipe_wdata,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_waddr,
  input  logic [31:0] mdu_wdata,
  input  logic        issue_en,
  input  logic [4:0]  issue_addr,
  input  logic [4:0]  chk_addr0,
  input  logic [4:0]  chk_addr1,
  output logic        busy0,
  output logic        busy1,
  output logic        pipe_stall,
  output logic        waw_err,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        rf_wren
);
  localparam int PW = (MDU_DEPTH > 1) ? $clog2(MDU_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wb_ent_t;

  wb_ent_t         fifo [MDU_DEPTH];
  wb_ent_t         head;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [SW-1:0]   starve;
  logic [31:0]     busy;
  logic            push, pop, pipe_take, fifo_empty;

  assign fifo_empty = (count == '0);
  // Ready comes only from the registered count, so there is no path from mdu_valid.
  assign mdu_ready  = (count != CW'(MDU_DEPTH));
  assign push       = mdu_valid && mdu_ready;
  assign pipe_take  = pipe_wren && (pipe_waddr != 5'd0);
  assign pop        = !pipe_take && !fifo_empty;
  assign head       = fifo[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= '{waddr: mdu_waddr, wdata: mdu_wdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // A popped r0 head is consumed silently; address and data hold while rf_wren is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wren  <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (pipe_take) begin
      rf_wren  <= 1'b1;
      rf_waddr <= pipe_waddr;
      rf_wdata <= pipe_wdata;
    end else if (pop && head.waddr != 5'd0) begin
      rf_wren  <= 1'b1;
      rf_waddr <= head.waddr;
      rf_wdata <= head.wdata;
    end else begin
      rf_wren  <= 1'b0;
    end
  end

  // Set beats clear on the same address; busy[0] is never written after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (issue_en && issue_addr == 5'(i))   busy[i] <= 1'b1;
        else if (pop && head.waddr == 5'(i))   busy[i] <= 1'b0;
      end
    end
  end

  assign busy0 = busy[chk_addr0];
  assign busy1 = busy[chk_addr1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            waw_err <= 1'b0;
    else if (pipe_take && busy[pipe_waddr]) waw_err <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          starve <= '0;
    else if (fifo_empty || pop)          starve <= '0;
    else if (starve != SW'(STARVE_MAX))  starve <= starve + SW'(1);
  end

  assign pipe_stall = (starve == SW'(STARVE_MAX));
endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Directed bench for reg_writeback_arbiter: linear steps with hand-computed
// expectations, checked by immediate assertions.
module tb_reg_writeback_arbiter;
  logic        clk, rst_n;
  logic        pipe_wren, mdu_valid, mdu_ready, issue_en;
  logic [4:0]  pipe_waddr, mdu_waddr, issue_addr, chk_addr0, chk_addr1, rf_waddr;
  logic [31:0] pipe_wdata, mdu_wdata, rf_wdata;
  logic        busy0, busy1, pipe_stall, waw_err, rf_wren;
  int checks = 0;
  int errors = 0;

  reg_writeback_arbiter #(.MDU_DEPTH(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_wren(pipe_wren), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_waddr(mdu_waddr), .mdu_wdata(mdu_wdata),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .chk_addr0(chk_addr0), .chk_addr1(chk_addr1), .busy0(busy0), .busy1(busy1),
    .pipe_stall(pipe_stall), .waw_err(waw_err),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wren(rf_wren)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    pipe_wren = 0; pipe_waddr = 0; pipe_wdata = 0;
    mdu_valid = 0; mdu_waddr = 0; mdu_wdata = 0;
    issue_en = 0; issue_addr = 0; chk_addr0 = 0; chk_addr1 = 0;
    #12;
    chk("rst_rf_wren", rf_wren, 0);
    chk("rst_rf_waddr", rf_waddr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_mdu_ready", mdu_ready, 1);
    chk("rst_pipe_stall", pipe_stall, 0);
    chk("rst_waw_err", waw_err, 0);
    chk("rst_busy0", busy0, 0);

    // 1: pipe write latency and hold
    rst_n = 1'b1;
    pipe_wren = 1; pipe_waddr = 5; pipe_wdata = 32'h1234;
    step();
    chk("t1_wren", rf_wren, 1);
    chk("t1_waddr", rf_waddr, 5);
    chk("t1_wdata", rf_wdata, 32'h1234);
    pipe_wren = 0;
    step();
    chk("t1_idle_wren", rf_wren, 0);
    chk("t1_hold_wdata", rf_wdata, 32'h1234);

    // 2: issue r7, MDU result drains one edge after acceptance
    issue_en = 1; issue_addr = 7; chk_addr0 = 7;
    step();
    issue_en = 0;
    chk("t2_busy_set", busy0, 1);
    mdu_valid = 1; mdu_waddr = 7; mdu_wdata = 32'hDEADBEEF;
    step();
    mdu_valid = 0;
    chk("t2_no_bypass", rf_wren, 0);
    chk("t2_busy_pending", busy0, 1);
    step();
    chk("t2_wren", rf_wren, 1);
    chk("t2_waddr", rf_waddr, 7);
    chk("t2_wdata", rf_wdata, 32'hDEADBEEF);
    chk("t2_busy_clr", busy0, 0);

    // 3: fill FIFO under constant pipe traffic, starve, then drain
    pipe_wren = 1; pipe_waddr = 9; pipe_wdata = 32'h99;
    mdu_valid = 1; mdu_waddr = 3; mdu_wdata = 32'h33;
    step();
    mdu_waddr = 4; mdu_wdata = 32'h44;
    step();
    mdu_valid = 0;
    chk("t3_full_ready", mdu_ready, 0);
    chk("t3_pipe_waddr", rf_waddr, 9);
    step();
    step();
    chk("t3_stall_early", pipe_stall, 0);
    step();
    chk("t3_stall", pipe_stall, 1);
    step();
    chk("t3_stall_hold", pipe_stall, 1);
    chk("t3_pipe_wins", rf_waddr, 9);
    pipe_wren = 0;
    step();
    chk("t3_pop1_wren", rf_wren, 1);
    chk("t3_pop1_waddr", rf_waddr, 3);
    chk("t3_pop1_wdata", rf_wdata, 32'h33);
    chk("t3_ready_back", mdu_ready, 1);
    chk("t3_stall_clr", pipe_stall, 0);
    step();
    chk("t3_pop2_waddr", rf_waddr, 4);
    chk("t3_pop2_wdata", rf_wdata, 32'h44);
    step();
    chk("t3_drained", rf_wren, 0);

    // 4: r0 writes from both sources are dropped
    pipe_wren = 1; pipe_waddr = 0; pipe_wdata = 32'h55;
    mdu_valid = 1; mdu_waddr = 0; mdu_wdata = 32'h66;
    issue_en = 1; issue_addr = 0; chk_addr0 = 0;
    step();
    mdu_valid = 0; issue_en = 0;
    chk("t4_wren_a", rf_wren, 0);
    chk("t4_busy_r0", busy0, 0);
    step();
    pipe_wren = 0;
    chk("t4_wren_b", rf_wren, 0);
    chk("t4_ready", mdu_ready, 1);
    step();
    chk("t4_wren_c", rf_wren, 0);
    chk("t4_waddr_hold", rf_waddr, 4);
    chk("t4_no_stall", pipe_stall, 0);

    // 5: WAW on a busy register
    issue_en = 1; issue_addr = 8; chk_addr1 = 8;
    step();
    issue_en = 0;
    chk("t5_busy", busy1, 1);
    chk("t5_waw_pre", waw_err, 0);
    pipe_wren = 1; pipe_waddr = 8; pipe_wdata = 32'h88;
    step();
    pipe_wren = 0;
    chk("t5_wren", rf_wren, 1);
    chk("t5_waddr", rf_waddr, 8);
    chk("t5_waw", waw_err, 1);
    step();
    step();
    chk("t5_waw_sticky", waw_err, 1);

    // 6: asynchronous reset with one buffered entry
    issue_en = 1; issue_addr = 2; chk_addr0 = 2;
    step();
    issue_en = 0;
    chk("t6_busy", busy0, 1);
    pipe_wren = 1; pipe_waddr = 9; pipe_wdata = 32'h77;
    mdu_valid = 1; mdu_waddr = 2; mdu_wdata = 32'h22;
    step();
    mdu_valid = 0;
    chk("t6_pipe_pre", rf_wren, 1);
    chk("t6_ready_pre", mdu_ready, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_wren", rf_wren, 0);
    chk("t6_rst_stall", pipe_stall, 0);
    chk("t6_rst_busy0", busy0, 0);
    chk("t6_rst_busy1", busy1, 0);
    chk("t6_rst_waw", waw_err, 0);
    chk("t6_rst_waddr", rf_waddr, 0);
    pipe_wren = 0;
    #2 rst_n = 1'b1;
    step();
    chk("t6_no_write_a", rf_wren, 0);
    step();
    chk("t6_no_write_b", rf_wren, 0);
    chk("t6_busy_after", busy0, 0);
    chk("t6_ready_after", mdu_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_writeback_arbiter.md
Name: reg_writeback_arbiter

Overview:
- Sits directly upstream of the CPU register file and drives its single write port (waddr/wdata/wren).
- Merges two result sources:
  - the in-order pipeline writeback, which is single-cycle and has priority;
  - a multi-cycle multiply/divide unit (MDU), which uses a valid/ready handshake into a small FIFO.
- Keeps a 32-bit busy scoreboard for outstanding MDU destinations so decode can stall on RAW/WAW hazards.
- Raises a stall request when MDU results are starved.

Parameters:
- MDU_DEPTH, 2, number of MDU result FIFO entries (power of two, ≥2).
- STARVE_MAX, 4, consecutive undrained cycles with a non-empty FIFO before pipe_stall asserts.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pipe_wren  input  1  pipeline writeback valid.
- pipe_waddr  input  5  pipeline destination register.
- pipe_wdata  input  32  pipeline result.
- mdu_valid  input  1  MDU result valid.
- mdu_ready  output  1  FIFO can accept an MDU result.
- mdu_waddr  input  5  MDU destination register.
- mdu_wdata  input  32  MDU result.
- issue_en  input  1  decode issued an MDU op this cycle.
- issue_addr  input  5  destination of the issued MDU op.
- chk_addr0  input  5  decode source/dest query 0.
- chk_addr1  input  5  decode source/dest query 1.
- busy0  output  1  busy bit of chk_addr0.
- busy1  output  1  busy bit of chk_addr1.
- pipe_stall  output  1  request a pipeline writeback bubble.
- waw_err  output  1  sticky: pipeline wrote a busy register.
- rf_waddr  output  5  register file write address.
- rf_wdata  output  32  register file write data.
- rf_wren  output  1  register file write enable.

Behaviour:
- **Reset** (asynchronous, rst_n=0):
  - rf_wren=0, rf_waddr=0, rf_wdata=0.
  - FIFO empty, all busy bits 0, starve counter 0.
  - pipe_stall=0, waw_err=0, mdu_ready=1.
  - Reset mid-operation discards buffered results and pending busy bits with no write.
- **Handshake:**
  - An MDU transfer occurs on a rising edge with mdu_valid && mdu_ready.
  - mdu_ready = !full; it is derived from registered count only and has no combinational path from mdu_valid.
  - An MDU result is always pushed into the FIFO; there is no bypass. Earliest drain is the next cycle.
- **Arbitration each cycle (priority order):**
  1. pipe_wren=1 and pipe_waddr≠0: register the pipe write into rf_*.
  2. Otherwise, if the FIFO is non-empty: pop the head and register it into rf_*.
  3. Otherwise rf_wren=0.
- **Register r0:**
  - pipe_wren with pipe_waddr=0 is a no-op: the slot counts as free, so the FIFO may drain.
  - A FIFO head with waddr=0 is popped with rf_wren=0.
- **Latency:**
  - Pipe inputs sampled at edge N appear on rf_* after edge N; the register file commits at edge N+1.
  - MDU accepted at edge N appears on rf_* at the earliest after edge N+1.
- **rf_wdata/rf_waddr** hold their last value when rf_wren=0.
- **FIFO:**
  - Circular pointers of width log2(MDU_DEPTH) plus an occupancy count (0..MDU_DEPTH).
  - Push and pop in the same cycle: count unchanged, legal when full because mdu_ready was already low, so there is no push.
  - Pointers wrap modulo MDU_DEPTH.
- **Scoreboard:**
  - issue_en sets busy[issue_addr]; writes to r0 are ignored, so busy[0] is always 0.
  - Popping an MDU entry clears busy[entry.waddr].
  - Set and clear of the same address in the same cycle: set wins.
  - busy0 = busy[chk_addr0] and busy1 = busy[chk_addr1], combinational from the registered bits.
- **WAW check:**
  - A pipe write accepted (pipe_wren, pipe_waddr≠0) while busy[pipe_waddr]=1 sets waw_err.
  - waw_err stays set until reset. The write still proceeds.
- **Starvation:**
  - The counter increments each cycle the FIFO is non-empty and no pop occurs, saturating at STARVE_MAX.
  - It clears on any pop or when the FIFO is empty.
  - pipe_stall = (counter == STARVE_MAX).
  - If pipe_wren arrives while pipe_stall=1, the pipe still wins and the counter holds.
- **Invariant:** no $display or side effects. rf_wren never asserts with rf_waddr=0.

Test Plan:
1. Reset then pipe_wren=1, waddr=5, wdata=0x1234 → after next edge rf_wren=1, rf_waddr=5, rf_wdata=0x1234; following idle cycle rf_wren=0 and rf_wdata stays 0x1234.
2. Issue r7, MDU result r7=0xDEADBEEF with no pipe traffic:
   - busy for r7 is 1 from the edge after issue_en.
   - One edge after acceptance rf_wren=1, waddr=7; busy for r7 returns to 0 on the same edge.
3. Fill the FIFO with 2 MDU results (r3, r4) while pipe_wren=1 every cycle to r9:
   - mdu_ready=0 after the second push.
   - pipe_stall=1 after 4 undrained cycles.
   - Pipe drops pipe_wren → r3 then r4 written on consecutive cycles; mdu_ready=1, pipe_stall=0.
4. pipe_wren to r0 and an MDU result to r0 → rf_wren never asserts; FIFO empties; busy[0] stays 0.
5. Issue r8 (busy), then pipe write to r8 → waw_err=1, the write to r8 still occurs, and waw_err remains 1 until rst_n pulses low.
6. Assert rst_n=0 asynchronously mid-cycle with 1 FIFO entry and busy for r2 set → rf_wren, pipe_stall, and busy outputs go to 0 immediately; after release no write for the dropped entry.
